// File: rtl/feature_out_reg_ctrl.sv
// Feature-out register matrix sequencer: walks every accumulation beat of a tile,
// hands the tile to the DDR writer, then clears the matrix. Optional macro: FOR_BIAS_WAIT_EN.
module feature_out_reg_ctrl #(
    parameter int US = 7,
    parameter int GN = 16,
    parameter int AW = 4,
    parameter int PW = 10
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          start_i,
    input  logic [AW-1:0] cfg_tx_i,
    input  logic [AW-1:0] cfg_ty_i,
    input  logic [4:0]    cfg_grp_i,
    input  logic [PW-1:0] cfg_pass_i,
    input  logic          conv_valid_i,
    output logic          conv_ready_o,
    input  logic          bias_full_i,
    output logic          accum_en_o,
    output logic [AW-1:0] addr_x_o,
    output logic [AW-1:0] addr_y_o,
    output logic [3:0]    grp_sel_o,
    output logic          wr_en_o,
    input  logic          wr_ack_i,
    output logic          wr_done_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACC,
        S_WRITE,
        S_CLEAR
    } state_t;

    state_t        state_q, state_d;
    logic          cfg_ok;
    logic          start_ok;
    logic          last_beat;
    logic          grp_wrap, x_wrap, y_wrap, pass_wrap;
    logic [AW-1:0] x_max_q, y_max_q;
    logic [3:0]    grp_max_q;
    logic [PW-1:0] pass_max_q;
    logic [PW-1:0] pass_cnt_q;
    logic          err_q;

    assign cfg_ok = (cfg_tx_i != '0) && (int'(cfg_tx_i) <= 2 * US) &&
                    (cfg_ty_i != '0) && (int'(cfg_ty_i) <= 2 * US) &&
                    (cfg_grp_i != '0) && (int'(cfg_grp_i) <= GN) &&
                    (cfg_pass_i != '0);

    assign start_ok = (state_q == S_IDLE) && start_i && cfg_ok;

    assign conv_ready_o = (state_q == S_ACC);
    assign accum_en_o   = conv_valid_i & conv_ready_o;
    assign wr_en_o      = (state_q == S_WRITE);
    assign wr_done_o    = (state_q == S_CLEAR);
    assign done_o       = (state_q == S_CLEAR);
    assign busy_o       = (state_q != S_IDLE);
    assign err_o        = err_q;

    assign grp_wrap  = (grp_sel_o == grp_max_q);
    assign x_wrap    = (addr_x_o == x_max_q);
    assign y_wrap    = (addr_y_o == y_max_q);
    assign pass_wrap = (pass_cnt_q == pass_max_q);
    assign last_beat = accum_en_o & grp_wrap & x_wrap & y_wrap & pass_wrap;

    // Limits are stored as last index so the wrap compares need no subtraction.
    always_ff @(posedge clk_i) begin
        if (start_ok) begin
            x_max_q    <= cfg_tx_i - AW'(1);
            y_max_q    <= cfg_ty_i - AW'(1);
            grp_max_q  <= 4'(cfg_grp_i - 5'd1);
            pass_max_q <= cfg_pass_i - PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == S_IDLE) && start_i && !cfg_ok;
        end
    end

    // grp is the fastest counter, then x, y, pass; all wrap to 0 after the last beat.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            grp_sel_o  <= '0;
            addr_x_o   <= '0;
            addr_y_o   <= '0;
            pass_cnt_q <= '0;
        end else if (start_ok) begin
            grp_sel_o  <= '0;
            addr_x_o   <= '0;
            addr_y_o   <= '0;
            pass_cnt_q <= '0;
        end else if (accum_en_o) begin
            if (!grp_wrap) begin
                grp_sel_o <= grp_sel_o + 4'd1;
            end else begin
                grp_sel_o <= '0;
                if (!x_wrap) begin
                    addr_x_o <= addr_x_o + AW'(1);
                end else begin
                    addr_x_o <= '0;
                    if (!y_wrap) begin
                        addr_y_o <= addr_y_o + AW'(1);
                    end else begin
                        addr_y_o   <= '0;
                        pass_cnt_q <= pass_wrap ? '0 : pass_cnt_q + PW'(1);
                    end
                end
            end
        end
    end

`ifndef FOR_BIAS_WAIT_EN
    logic unused_bias_full;
    assign unused_bias_full = bias_full_i;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_LOAD;
`ifdef FOR_BIAS_WAIT_EN
            // Bias wait: at least one cycle here even if the bias registers are already full.
            S_LOAD:  if (bias_full_i) state_d = S_ACC;
`else
            S_LOAD:  state_d = S_ACC;
`endif
            S_ACC:   if (last_beat) state_d = S_WRITE;
            S_WRITE: if (wr_ack_i) state_d = S_CLEAR;
            S_CLEAR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_feature_out_reg_ctrl.sv
// Scoreboard bench for feature_out_reg_ctrl: expected beats/done events are queued at stimulus
// time and popped by a monitor whenever the DUT asserts accum_en_o or wr_done_o.
`timescale 1ns/1ps
module tb_feature_out_reg_ctrl;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       start_i;
    logic [3:0] cfg_tx_i, cfg_ty_i;
    logic [4:0] cfg_grp_i;
    logic [9:0] cfg_pass_i;
    logic       conv_valid_i, conv_ready_o, bias_full_i, accum_en_o;
    logic [3:0] addr_x_o, addr_y_o, grp_sel_o;
    logic       wr_en_o, wr_ack_i, wr_done_o, busy_o, done_o, err_o;

    typedef struct packed {
        logic       done;
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] g;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    feature_out_reg_ctrl dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i),
        .cfg_tx_i(cfg_tx_i), .cfg_ty_i(cfg_ty_i), .cfg_grp_i(cfg_grp_i), .cfg_pass_i(cfg_pass_i),
        .conv_valid_i(conv_valid_i), .conv_ready_o(conv_ready_o), .bias_full_i(bias_full_i),
        .accum_en_o(accum_en_o), .addr_x_o(addr_x_o), .addr_y_o(addr_y_o), .grp_sel_o(grp_sel_o),
        .wr_en_o(wr_en_o), .wr_ack_i(wr_ack_i), .wr_done_o(wr_done_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected DUT event at %0t", name, $time);
    endtask

    // Monitor: every accepted beat and every wr_done pulse must match the queue head.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (accum_en_o) begin
                if (sb_q.size() == 0) fail_now("unexp_beat");
                else begin
                    mon_e = sb_q.pop_front();
                    chk("beat_kind", 32'(mon_e.done), 32'd0);
                    chk("beat_addr", {20'd0, addr_x_o, addr_y_o, grp_sel_o},
                        {20'd0, mon_e.x, mon_e.y, mon_e.g});
                end
            end
            if (wr_done_o) begin
                if (sb_q.size() == 0) fail_now("unexp_wr_done");
                else begin
                    mon_e = sb_q.pop_front();
                    chk("done_kind", 32'(mon_e.done), 32'd1);
                    chk("done_pulse", 32'(done_o), 32'd1);
                end
            end
        end
    end

    task automatic push_tile(input int tx, input int ty, input int grp, input int pass);
        for (int p = 0; p < pass; p++)
            for (int yy = 0; yy < ty; yy++)
                for (int xx = 0; xx < tx; xx++)
                    for (int gg = 0; gg < grp; gg++)
                        sb_q.push_back('{done: 1'b0, x: 4'(xx), y: 4'(yy), g: 4'(gg)});
        sb_q.push_back('{done: 1'b1, x: 4'd0, y: 4'd0, g: 4'd0});
    endtask

    task automatic run_tile(input int tx, input int ty, input int grp, input int pass,
                            input bit toggle, input int ack_dly, input bit poke_start);
        int n, beats, cyc, last_cyc, wr_cyc, bound;
        bit prev_idle;
        logic [11:0] idle_addr, cur_addr;
        n = tx * ty * grp * pass;
        push_tile(tx, ty, grp, pass);
        cfg_tx_i = 4'(tx); cfg_ty_i = 4'(ty); cfg_grp_i = 5'(grp); cfg_pass_i = 10'(pass);
        start_i = 1'b1;
        conv_valid_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        chk("busy_after_start", 32'(busy_o), 32'd1);
        chk("ready_lat1", 32'(conv_ready_o), 32'd0);
        @(negedge clk_i);
        chk("ready_lat2", 32'(conv_ready_o), 32'd1);
        beats = 0; cyc = 0; last_cyc = -1; wr_cyc = -1; prev_idle = 0; idle_addr = '0;
        bound = 2 * n + 20;
        while (cyc < bound) begin
            cur_addr = {addr_x_o, addr_y_o, grp_sel_o};
            if (wr_en_o) begin
                wr_cyc = cyc;
                break;
            end
            if (accum_en_o) begin
                beats++;
                last_cyc = cyc;
                if (prev_idle) chk("hold_addr", 32'(cur_addr), 32'(idle_addr));
                prev_idle = 0;
            end else if (conv_ready_o) begin
                prev_idle = 1;
                idle_addr = cur_addr;
            end
            @(posedge clk_i); #1;
            if (toggle) conv_valid_i = ~conv_valid_i;
            if (poke_start && cyc == 3) begin
                cfg_grp_i = 5'd0;
                start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            cyc++;
            @(negedge clk_i);
            if (poke_start && cyc >= 4 && cyc <= 6) chk("no_err_in_acc", 32'(err_o), 32'd0);
        end
        start_i = 1'b0;
        conv_valid_i = 1'b0;
        chk("beat_count", 32'(beats), 32'(n));
        chk("wr_en_lat", 32'(wr_cyc), 32'(last_cyc + 1));
        if (wr_cyc < 0) return;
        for (int i = 0; i < ack_dly; i++) begin
            chk("wr_en_hold", 32'(wr_en_o), 32'd1);
            @(negedge clk_i);
        end
        wr_ack_i = 1'b1;
        chk("wr_en_at_ack", 32'(wr_en_o), 32'd1);
        @(posedge clk_i); #1;
        wr_ack_i = 1'b0;
        @(negedge clk_i);
        chk("wr_done_lat", 32'(wr_done_o), 32'd1);
        chk("done_lat", 32'(done_o), 32'd1);
        chk("wr_en_drop", 32'(wr_en_o), 32'd0);
        @(negedge clk_i);
        chk("done_single", 32'(done_o), 32'd0);
        chk("idle_after", 32'(busy_o), 32'd0);
    endtask

    task automatic err_case(input int tx, input int ty, input int grp, input int pass);
        cfg_tx_i = 4'(tx); cfg_ty_i = 4'(ty); cfg_grp_i = 5'(grp); cfg_pass_i = 10'(pass);
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        chk("err_pulse", 32'(err_o), 32'd1);
        chk("err_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        chk("err_clear", 32'(err_o), 32'd0);
        chk("err_stay_idle", 32'(busy_o), 32'd0);
    endtask

    task automatic reset_mid_acc();
        int beats;
        push_tile(2, 1, 3, 2);
        cfg_tx_i = 4'd2; cfg_ty_i = 4'd1; cfg_grp_i = 5'd3; cfg_pass_i = 10'd2;
        start_i = 1'b1;
        conv_valid_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        beats = 0;
        for (int i = 0; i < 30 && beats < 5; i++) begin
            @(negedge clk_i);
            if (accum_en_o) beats++;
        end
        chk("rst_pre_beats", 32'(beats), 32'd5);
        #2 rstn_i = 1'b0;
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ready", 32'(conv_ready_o), 32'd0);
        chk("rst_accum", 32'(accum_en_o), 32'd0);
        chk("rst_addr", {20'd0, addr_x_o, addr_y_o, grp_sel_o}, 32'd0);
        chk("rst_wr", {28'd0, wr_en_o, wr_done_o, done_o, err_o}, 32'd0);
        sb_q.delete();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (6) @(negedge clk_i);
        chk("rst_stays_idle", 32'(busy_o), 32'd0);
        conv_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i = 1'b0; start_i = 1'b0; conv_valid_i = 1'b0; bias_full_i = 1'b1; wr_ack_i = 1'b0;
        cfg_tx_i = '0; cfg_ty_i = '0; cfg_grp_i = '0; cfg_pass_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_ready", 32'(conv_ready_o), 32'd0);
        chk("reset_addr", {20'd0, addr_x_o, addr_y_o, grp_sel_o}, 32'd0);
        chk("reset_flags", {28'd0, wr_en_o, wr_done_o, done_o, err_o}, 32'd0);
        rstn_i = 1'b1;
        @(negedge clk_i);

        run_tile(2, 1, 3, 2, 1'b0, 2, 1'b0);
        run_tile(2, 1, 3, 2, 1'b1, 7, 1'b1);
        run_tile(3, 2, 1, 1, 1'b0, 0, 1'b0);
        run_tile(14, 1, 16, 1, 1'b0, 1, 1'b0);
        run_tile(1, 14, 2, 3, 1'b1, 0, 1'b0);

        err_case(2, 1, 0, 1);
        err_case(15, 1, 3, 1);
        err_case(2, 0, 3, 1);
        err_case(2, 1, 17, 1);
        err_case(2, 1, 3, 0);

        reset_mid_acc();
        run_tile(2, 2, 2, 1, 1'b0, 3, 1'b0);

        repeat (3) @(negedge clk_i);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
